decode_ctrl_stage: RTL

- Parametrised, registered successor to the RV32I control decoder.
- Decodes one instruction per cycle into control, register indices and sign-extended immediate, and holds the result in an ID/EX pipeline register.
- Valid/ready handshake on both sides, plus flush.
- Optional RV32M decode and illegal-instruction flagging. Sits between the IF/ID register and the execute stage.

---
 rtl/decode_pkg.sv | 71 +++++++
 rtl/decode_ctrl_comb.sv | 137 +++++++++++++
 rtl/decode_ctrl_stage.sv | 99 +++++++++
 3 files changed

// File: rtl/decode_pkg.sv
// Shared encodings for the RV32I/M decode stage: opcodes, ALU operations,
// writeback source selects and the decoded control bundle.
package decode_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] M2R_ALU  = 2'b00;
    localparam logic [1:0] M2R_LOAD = 2'b01;
    localparam logic [1:0] M2R_PC4  = 2'b10;

    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL,
        ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B, ALU_MUL, ALU_MULH,
        ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
    } alu_op_e;

    typedef struct packed {
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] funct3;
        logic       reg_write;
        logic [1:0] mem_to_reg;
        logic       is_load;
        logic       is_store;
        logic       is_branch;
        logic       is_jal;
        logic       is_jalr;
        logic       is_muldiv;
        logic       opa_sel;
        logic       opb_sel;
        alu_op_e    alu_op;
        logic       illegal;
    } decode_t;

    // alt selects SUB/SRA for the funct3 slots that have an alternate form
    function automatic alu_op_e base_alu(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  base_alu = alt ? ALU_SUB : ALU_ADD;
            3'b001:  base_alu = ALU_SLL;
            3'b010:  base_alu = ALU_SLT;
            3'b011:  base_alu = ALU_SLTU;
            3'b100:  base_alu = ALU_XOR;
            3'b101:  base_alu = alt ? ALU_SRA : ALU_SRL;
            3'b110:  base_alu = ALU_OR;
            default: base_alu = ALU_AND;
        endcase
    endfunction

    function automatic alu_op_e muldiv_alu(input logic [2:0] f3);
        case (f3)
            3'b000:  muldiv_alu = ALU_MUL;
            3'b001:  muldiv_alu = ALU_MULH;
            3'b010:  muldiv_alu = ALU_MULHSU;
            3'b011:  muldiv_alu = ALU_MULHU;
            3'b100:  muldiv_alu = ALU_DIV;
            3'b101:  muldiv_alu = ALU_DIVU;
            3'b110:  muldiv_alu = ALU_REM;
            default: muldiv_alu = ALU_REMU;
        endcase
    endfunction

endpackage

// File: rtl/decode_ctrl_comb.sv
// Purely combinational instruction decoder: control bundle, register
// indices, sign-extended immediate and illegal-instruction detection.
module decode_ctrl_comb
    import decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int EN_M = 0
) (
    input  logic [31:0]     i_instr,
    output decode_t         o_dec,
    output logic [XLEN-1:0] o_imm
);

    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm32;
    decode_t     w_dec;

    assign w_opcode = i_instr[6:0];
    assign w_f3     = i_instr[14:12];
    assign w_f7     = i_instr[31:25];

    always_comb begin
        w_dec          = '0;
        w_imm32        = '0;
        w_dec.rd       = i_instr[11:7];
        w_dec.rs1      = i_instr[19:15];
        w_dec.rs2      = i_instr[24:20];
        w_dec.funct3   = w_f3;
        w_dec.alu_op   = ALU_ADD;

        case (w_opcode)
            OP_R: begin
                w_dec.reg_write = 1'b1;
                if (w_f7 == 7'b0000000) begin
                    w_dec.alu_op = base_alu(w_f3, 1'b0);
                end else if (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101)) begin
                    w_dec.alu_op = base_alu(w_f3, 1'b1);
                end else if (w_f7 == 7'b0000001 && EN_M != 0) begin
                    w_dec.is_muldiv = 1'b1;
                    w_dec.alu_op    = muldiv_alu(w_f3);
                end else begin
                    w_dec.illegal = 1'b1;
                end
            end
            OP_IMM: begin
                w_dec.reg_write = 1'b1;
                w_dec.opb_sel   = 1'b1;
                w_imm32         = {{20{i_instr[31]}}, i_instr[31:20]};
                // Only the shift-immediates carry a funct7 field
                if (w_f3 == 3'b001) begin
                    w_dec.alu_op  = ALU_SLL;
                    w_dec.illegal = (w_f7 != 7'b0000000);
                end else if (w_f3 == 3'b101) begin
                    w_dec.alu_op  = base_alu(w_f3, i_instr[30]);
                    w_dec.illegal = (w_f7 != 7'b0000000) && (w_f7 != 7'b0100000);
                end else begin
                    w_dec.alu_op = base_alu(w_f3, 1'b0);
                end
            end
            OP_LOAD: begin
                w_dec.reg_write  = 1'b1;
                w_dec.is_load    = 1'b1;
                w_dec.opb_sel    = 1'b1;
                w_dec.mem_to_reg = M2R_LOAD;
                w_imm32          = {{20{i_instr[31]}}, i_instr[31:20]};
                w_dec.illegal    = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
            end
            OP_STORE: begin
                w_dec.is_store = 1'b1;
                w_dec.opb_sel  = 1'b1;
                w_imm32        = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
                w_dec.illegal  = (w_f3 > 3'b010);
            end
            OP_BRANCH: begin
                w_dec.is_branch = 1'b1;
                w_dec.alu_op    = ALU_SUB;
                w_imm32         = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                                   i_instr[30:25], i_instr[11:8], 1'b0};
                w_dec.illegal   = (w_f3 == 3'b010) || (w_f3 == 3'b011);
            end
            OP_JAL: begin
                w_dec.reg_write  = 1'b1;
                w_dec.is_jal     = 1'b1;
                w_dec.opa_sel    = 1'b1;
                w_dec.opb_sel    = 1'b1;
                w_dec.mem_to_reg = M2R_PC4;
                w_imm32          = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                                    i_instr[20], i_instr[30:21], 1'b0};
            end
            OP_JALR: begin
                w_dec.reg_write  = 1'b1;
                w_dec.is_jalr    = 1'b1;
                w_dec.opb_sel    = 1'b1;
                w_dec.mem_to_reg = M2R_PC4;
                w_imm32          = {{20{i_instr[31]}}, i_instr[31:20]};
                w_dec.illegal    = (w_f3 != 3'b000);
            end
            OP_LUI: begin
                w_dec.reg_write = 1'b1;
                w_dec.opb_sel   = 1'b1;
                w_dec.alu_op    = ALU_PASS_B;
                w_imm32         = {i_instr[31:12], 12'h000};
            end
            OP_AUIPC: begin
                w_dec.reg_write = 1'b1;
                w_dec.opa_sel   = 1'b1;
                w_dec.opb_sel   = 1'b1;
                w_imm32         = {i_instr[31:12], 12'h000};
            end
            default: w_dec.illegal = 1'b1;
        endcase

        if (i_instr[1:0] != 2'b11) begin
            w_dec.illegal = 1'b1;
        end

        // Illegal entries still flow downstream but must not cause side effects
        if (w_dec.illegal) begin
            w_dec.reg_write = 1'b0;
            w_dec.is_load   = 1'b0;
            w_dec.is_store  = 1'b0;
            w_dec.is_branch = 1'b0;
            w_dec.is_jal    = 1'b0;
            w_dec.is_jalr   = 1'b0;
            w_dec.is_muldiv = 1'b0;
        end
        if (w_dec.rd == 5'd0) begin
            w_dec.reg_write = 1'b0;
        end
    end

    assign o_dec = w_dec;
    assign o_imm = XLEN'($signed(w_imm32));

endmodule

// File: rtl/decode_ctrl_stage.sv
// Registered decode stage: wraps decode_ctrl_comb with a valid/ready
// ID/EX pipeline register and a highest-priority flush.
module decode_ctrl_stage
    import decode_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int EN_M     = 0,
    parameter int ALU_OP_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instr,
    input  logic [XLEN-1:0]     in_pc,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_pc,
    output logic [4:0]          out_rd,
    output logic [4:0]          out_rs1,
    output logic [4:0]          out_rs2,
    output logic [XLEN-1:0]     out_imm,
    output logic                dec_reg_write,
    output logic [1:0]          dec_mem_to_reg,
    output logic                dec_is_load,
    output logic                dec_is_store,
    output logic                dec_is_branch,
    output logic                dec_is_jal,
    output logic                dec_is_jalr,
    output logic                dec_is_muldiv,
    output logic                dec_opa_sel,
    output logic                dec_opb_sel,
    output logic [ALU_OP_W-1:0] dec_alu_op,
    output logic [2:0]          dec_funct3,
    output logic                dec_illegal
);

    decode_t         w_dec;
    logic [XLEN-1:0] w_imm;
    logic            w_accept;

    decode_t         r_dec;
    logic [XLEN-1:0] r_imm;
    logic [XLEN-1:0] r_pc;
    logic            r_valid;

    decode_ctrl_comb #(
        .XLEN (XLEN),
        .EN_M (EN_M)
    ) u_comb (
        .i_instr (in_instr),
        .o_dec   (w_dec),
        .o_imm   (w_imm)
    );

    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready && !flush;

    // Flush outranks accept; data registers only move on an accept
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_dec   <= '0;
            r_imm   <= '0;
            r_pc    <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_dec   <= w_dec;
            r_imm   <= w_imm;
            r_pc    <= in_pc;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid      = r_valid;
    assign out_pc         = r_pc;
    assign out_imm        = r_imm;
    assign out_rd         = r_dec.rd;
    assign out_rs1        = r_dec.rs1;
    assign out_rs2        = r_dec.rs2;
    assign dec_reg_write  = r_dec.reg_write;
    assign dec_mem_to_reg = r_dec.mem_to_reg;
    assign dec_is_load    = r_dec.is_load;
    assign dec_is_store   = r_dec.is_store;
    assign dec_is_branch  = r_dec.is_branch;
    assign dec_is_jal     = r_dec.is_jal;
    assign dec_is_jalr    = r_dec.is_jalr;
    assign dec_is_muldiv  = r_dec.is_muldiv;
    assign dec_opa_sel    = r_dec.opa_sel;
    assign dec_opb_sel    = r_dec.opb_sel;
    assign dec_alu_op     = ALU_OP_W'(r_dec.alu_op);
    assign dec_funct3     = r_dec.funct3;
    assign dec_illegal    = r_dec.illegal;

endmodule
